// File: rtl/text_write_arbiter_pkg.sv
// Shared widths, state encoding and write-entry type for the text write arbiter.
package text_pkg;

    localparam int CHAR_W        = 4;
    localparam int ADDR_W        = 12;
    localparam int CELLS_DEFAULT = 2400;
    localparam logic [CHAR_W-1:0] BLANK_DEFAULT = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [CHAR_W-1:0] chr;
        logic [ADDR_W-1:0] addr;
    } text_wr_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int cells);
        return ({{(32-ADDR_W){1'b0}}, addr} < 32'(cells));
    endfunction

endpackage

// File: rtl/text_write_arbiter_if.sv
// CPU write bus plus text-buffer write port, as seen by the arbiter (slave) and its driver (master).
interface text_write_arbiter_if;
    import text_pkg::*;

    logic [CHAR_W-1:0] cpu_char;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_valid;
    logic              cpu_ready;
    logic              clr_req;
    logic              clr_busy;
    logic              addr_err;
    logic [CHAR_W-1:0] new_char;
    logic [ADDR_W-1:0] waddr;
    logic              text_en;

    modport slave (
        input  cpu_char, cpu_addr, cpu_valid, clr_req,
        output cpu_ready, clr_busy, addr_err, new_char, waddr, text_en
    );

    modport master (
        output cpu_char, cpu_addr, cpu_valid, clr_req,
        input  cpu_ready, clr_busy, addr_err, new_char, waddr, text_en
    );

endinterface

// File: rtl/text_write_arbiter_fifo.sv
// Synchronous FIFO of CPU text writes; extra pointer MSB distinguishes full from empty.
module text_wr_fifo
    import text_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  text_wr_t                   wdata,
    input  logic                       pop,
    output text_wr_t                   rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    text_wr_t      mem_q [DEPTH];
    text_wr_t      mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/text_write_arbiter.sv
// Orders CPU writes and full-screen clears onto the text buffer write port.
//   state | meaning
//   IDLE  | pop CPU FIFO whenever non-empty; accept clr_req
//   DRAIN | pop only the entries queued before clr_req
//   CLEAR | write BLANK_CHAR to every cell 0..CELLS-1, no pops
module text_write_arbiter
    import text_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                CELLS      = CELLS_DEFAULT,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = BLANK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    text_write_arbiter_if.slave  bus
);

    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              text_en_q, text_en_d;
    logic              addr_err_q, addr_err_d;
    logic [CHAR_W-1:0] new_char_q, new_char_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    logic              push, pop, full, empty;
    logic [CW-1:0]     count;
    text_wr_t          wdata, rdata;

    assign push  = bus.cpu_valid && !full;
    assign wdata = '{chr: bus.cpu_char, addr: bus.cpu_addr};

    text_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            clr_addr_q  <= '0;
            text_en_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            new_char_q  <= '0;
            waddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            clr_addr_q  <= clr_addr_d;
            text_en_q   <= text_en_d;
            addr_err_q  <= addr_err_d;
            new_char_q  <= new_char_d;
            waddr_q     <= waddr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        clr_addr_d  = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    drain_cnt_d = count;
                    state_d     = (count == '0) ? CLEAR : DRAIN;
                end
            end
            DRAIN: begin
                if (pop) begin
                    drain_cnt_d = drain_cnt_q - CW'(1);
                    if (drain_cnt_q == CW'(1)) state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    clr_addr_d = '0;
                    state_d    = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The IDLE pop is held off on the clr_req edge so the snapshot covers exactly the queued entries.
    always_comb begin
        pop        = 1'b0;
        text_en_d  = 1'b0;
        addr_err_d = 1'b0;
        new_char_d = new_char_q;
        waddr_d    = waddr_q;
        case (state_q)
            IDLE:  pop = !empty && !bus.clr_req;
            DRAIN: pop = !empty;
            CLEAR: begin
                text_en_d  = 1'b1;
                new_char_d = BLANK_CHAR;
                waddr_d    = clr_addr_q;
            end
            default: pop = 1'b0;
        endcase
        if (pop) begin
            if (addr_in_range(rdata.addr, CELLS)) begin
                text_en_d  = 1'b1;
                new_char_d = rdata.chr;
                waddr_d    = rdata.addr;
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    assign bus.cpu_ready = !full;
    assign bus.clr_busy  = (state_q != IDLE);
    assign bus.addr_err  = addr_err_q;
    assign bus.new_char  = new_char_q;
    assign bus.waddr     = waddr_q;
    assign bus.text_en   = text_en_q;

endmodule

// File: tb/tb_text_write_arbiter.sv
// Directed self-checking bench for text_write_arbiter.
module tb_text_write_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic ready_at3;

    text_write_arbiter_if bus();

    text_write_arbiter #(
        .FIFO_DEPTH (4),
        .CELLS      (2400),
        .BLANK_CHAR (4'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps through a full 2400-cell clear; optionally pushes CPU entries and re-requests a clear.
    task automatic run_clear(input int push_n, input logic [11:0] push_base, input int req_at);
        int bad;
        bad = 0;
        for (int n = 0; n < 2400; n++) begin
            if (n < push_n) begin
                bus.cpu_valid = 1'b1;
                bus.cpu_char  = 4'(n + 1);
                bus.cpu_addr  = push_base + 12'(n);
            end else begin
                bus.cpu_valid = 1'b0;
            end
            bus.clr_req = (n == req_at);
            step();
            if (bus.text_en !== 1'b1 || bus.waddr !== 12'(n) ||
                bus.new_char !== 4'h0 || bus.addr_err !== 1'b0) bad++;
            if (n < 2399 && bus.clr_busy !== 1'b1) bad++;
            if (n == 3) ready_at3 = bus.cpu_ready;
        end
        bus.cpu_valid = 1'b0;
        bus.clr_req   = 1'b0;
        check("clear_sequence", 32'(bad), 32'd0);
    endtask

    initial begin
        int en_seen;
        checks        = 0;
        errors        = 0;
        ready_at3     = 1'b1;
        bus.cpu_char  = '0;
        bus.cpu_addr  = '0;
        bus.cpu_valid = 1'b0;
        bus.clr_req   = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;
        #2;

        // Reset state
        check("rst_text_en",  bus.text_en,   1'b0);
        check("rst_waddr",    bus.waddr,     12'd0);
        check("rst_new_char", bus.new_char,  4'h0);
        check("rst_addr_err", bus.addr_err,  1'b0);
        check("rst_clr_busy", bus.clr_busy,  1'b0);
        check("rst_ready",    bus.cpu_ready, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Single write: accepted at edge k, visible after edge k+1, one cycle only
        bus.cpu_char = 4'hA; bus.cpu_addr = 12'd81; bus.cpu_valid = 1'b1;
        step();
        bus.cpu_valid = 1'b0;
        check("single_no_early", bus.text_en, 1'b0);
        step();
        check("single_en",    bus.text_en,  1'b1);
        check("single_waddr", bus.waddr,    12'd81);
        check("single_char",  bus.new_char, 4'hA);
        step();
        check("single_one_cycle", bus.text_en, 1'b0);

        // Bad address followed by a good entry
        bus.cpu_char = 4'h3; bus.cpu_addr = 12'd2400; bus.cpu_valid = 1'b1;
        step();
        bus.cpu_char = 4'h5; bus.cpu_addr = 12'd10;
        step();
        bus.cpu_valid = 1'b0;
        check("bad_err",    bus.addr_err, 1'b1);
        check("bad_no_en",  bus.text_en,  1'b0);
        step();
        check("bad_err_one_cycle", bus.addr_err, 1'b0);
        check("next_en",    bus.text_en,  1'b1);
        check("next_waddr", bus.waddr,    12'd10);
        check("next_char",  bus.new_char, 4'h5);
        step();
        check("next_done", bus.text_en, 1'b0);

        // Clear from empty IDLE, FIFO filled during clear, repeated clr_req at address 1000
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        check("clr_busy_rise", bus.clr_busy, 1'b1);
        check("clr_no_en_yet", bus.text_en,  1'b0);
        run_clear(5, 12'd100, 1000);
        check("full_ready_low", ready_at3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("full_order_en",    bus.text_en,  1'b1);
            check("full_order_waddr", bus.waddr,    12'd100 + 12'(i));
            check("full_order_char",  bus.new_char, 4'(i + 1));
            check("full_busy_low",    bus.clr_busy, 1'b0);
        end
        step();
        check("full_fifth_ignored", bus.text_en, 1'b0);

        // Ordering across a clear: 5,6 queued before clr_req, 7 pushed during DRAIN
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        run_clear(2, 12'd5, -1);
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        check("ord_busy_rise", bus.clr_busy, 1'b1);
        check("ord_no_pop_on_req", bus.text_en, 1'b0);
        bus.cpu_char = 4'h9; bus.cpu_addr = 12'd7; bus.cpu_valid = 1'b1;
        step();
        bus.cpu_valid = 1'b0;
        check("ord_w5_waddr", bus.waddr,    12'd5);
        check("ord_w5_char",  bus.new_char, 4'h1);
        check("ord_w5_busy",  bus.clr_busy, 1'b1);
        step();
        check("ord_w6_en",    bus.text_en,  1'b1);
        check("ord_w6_waddr", bus.waddr,    12'd6);
        check("ord_w6_busy",  bus.clr_busy, 1'b1);
        run_clear(0, 12'd0, -1);
        step();
        check("ord_w7_en",    bus.text_en,  1'b1);
        check("ord_w7_waddr", bus.waddr,    12'd7);
        check("ord_w7_char",  bus.new_char, 4'h9);
        step();
        check("ord_done", bus.text_en, 1'b0);

        // Reset mid-CLEAR with three entries queued
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.cpu_char = 4'hC; bus.cpu_addr = 12'd300 + 12'(i); bus.cpu_valid = 1'b1;
            step();
        end
        bus.cpu_valid = 1'b0;
        check("mid_clear_en", bus.text_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en",    bus.text_en,   1'b0);
        check("mid_rst_waddr", bus.waddr,     12'd0);
        check("mid_rst_busy",  bus.clr_busy,  1'b0);
        check("mid_rst_ready", bus.cpu_ready, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.text_en !== 1'b0) en_seen++;
        end
        check("post_rst_no_writes", 32'(en_seen), 32'd0);
        check("post_rst_busy",      bus.clr_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_write_arbiter.md
# text_write_arbiter

Sequences all writes into the text buffer's write port (`new_char`, `waddr`, `text_en`). It owns two write sources:
- a small FIFO of CPU character writes;
- a hardware screen-clear engine that fills every cell with a blank character.

Write order is strict: CPU writes accepted before a clear request land before the clear, and writes accepted after it land after it. The block sits between the CPU bus and `character_processor`, whose write inputs it drives directly.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: CPU write queue entries; power of two, at least 2.
- `CELLS`, 2400: valid text cells (80 columns × 30 rows); legal addresses are 0..CELLS-1.
- `BLANK_CHAR`, 4'h0: character code written by the clear engine.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cpu_char`, in, 4: character code to write.
- `cpu_addr`, in, 12: target cell address.
- `cpu_valid`, in, 1: CPU write request.
- `cpu_ready`, out, 1: FIFO can accept; equals !full, combinational from state.
- `clr_req`, in, 1: single-cycle clear request.
- `clr_busy`, out, 1: high in DRAIN or CLEAR state.
- `addr_err`, out, 1: one-cycle pulse when a popped CPU entry has cpu_addr ≥ CELLS.
- `new_char`, out, 4: registered write data to the text buffer.
- `waddr`, out, 12: registered write address to the text buffer.
- `text_en`, out, 1: registered write enable, one cycle per write.

## Operation
- **Push.** A CPU write is accepted on any rising edge with cpu_valid && cpu_ready, in every state.
- **Pop.** At most one FIFO pop per cycle. A popped entry drives the output registers on the same edge.
- **State IDLE.**
  - Pops whenever the FIFO is non-empty.
  - On clr_req: snapshot the current FIFO count into `drain_cnt`. Ignore any push or pop on that same edge when computing the snapshot; count = entries present before the edge.
  - If drain_cnt = 0, go to CLEAR. Otherwise go to DRAIN.
- **State DRAIN.**
  - Pops one entry per cycle and decrements drain_cnt.
  - Entries pushed after the request are not popped.
  - Goes to CLEAR on the edge that pops the last snapshotted entry.
- **State CLEAR.**
  - No pops.
  - Each cycle writes BLANK_CHAR to `clr_addr`, which runs 0, 1, … CELLS-1.
  - After writing CELLS-1, goes to IDLE and resets clr_addr to 0.
- **clr_req while clr_busy** is ignored; it is not queued.
- **Out-of-range entry.** Popping an entry with cpu_addr ≥ CELLS gives text_en = 0 and addr_err = 1 for that cycle. The entry is consumed and still counts toward drain_cnt.
- **Arithmetic.**
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB comparison.
  - clr_addr is 12 bits and never exceeds CELLS-1.
- **Full FIFO.** cpu_ready = 0. cpu_valid is ignored; the CPU must hold it.
- **Simultaneous push and pop on a full FIFO** is not permitted (ready is low). On a non-full FIFO both occur and the count is unchanged.

## Timing
- **Reset (async, rst_n low).** Takes effect immediately:
  - state = IDLE, FIFO empty, drain_cnt = 0, clr_addr = 0;
  - text_en = 0, new_char = 0, waddr = 0, addr_err = 0, clr_busy = 0;
  - cpu_ready = 1.
- **Reset mid-CLEAR or mid-DRAIN.** Aborts the operation. Queued entries are lost; the partial clear is not resumed.
- **CPU write latency.** Write accepted at edge k into an empty FIFO in IDLE → popped at edge k+1 → text_en high in the cycle after edge k+1.
- **Throughput.** One write per cycle from either source.
- **clr_busy** rises in the cycle after the clr_req edge. It falls in the cycle after the last clear write, i.e. it is low while text_en is low after the final clear write.
- **Clear duration.** Exactly CELLS consecutive text_en cycles, with no gaps.

## Structure
- Package `text_pkg` holds:
  - CHAR_W = 4, ADDR_W = 12, CELLS_DEFAULT = 2400, BLANK_DEFAULT;
  - typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} arb_state_t;
  - a packed struct `text_wr_t` {char, addr}.
- Sub-module `text_wr_fifo`: synchronous FIFO (push/pop/full/empty/count) storing text_wr_t, with the same async reset.
- The FSM, drain counter, clear counter and output registers live in the top module.

## Test plan
- **Reset mid-activity.** Push 3 writes, then assert rst_n = 0 → all outputs 0 immediately, cpu_ready = 1; after release the FIFO is empty and no text_en occurs.
- **Single write.** Push char 4'hA to addr 12'd81 at edge k → text_en = 1, waddr = 81, new_char = A in the cycle after edge k+1, for one cycle only.
- **Full FIFO.** Hold cpu_valid with clr_busy forcing no pops; after 4 accepts → cpu_ready = 0. Release → entries emerge in push order.
- **Ordering across a clear.** Queue 2 writes (addr 5, 6), then clr_req, then push addr 7 during DRAIN. Expect:
  - writes to 5 and 6;
  - then 2400 blank writes, addresses 0..2399;
  - then the write to 7.
  - clr_busy is high throughout the first two groups.
- **Bad address.** Push addr 12'd2400 → addr_err pulses for one cycle, no text_en; the following entry still drains normally.
- **Repeated clear request.** Assert clr_req again at clear address 1000 → ignored; exactly 2400 clear writes occur, then IDLE.
